interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Sits directly upstream of the control FSM's opcode input.
- Watches instruction boundaries (last_cycle from control) and arbitrates pending reset, NMI and IRQ requests.
- When an interrupt is taken, it substitutes the BRK opcode for the fetched byte so the control FSM runs its break/vector sequence.
- Supplies the vector address and the B-flag value for that sequence, and holds them until the control FSM signals that the vector has been loaded.

Parameters:
- RESET_VEC, 16'hFFFC: reset vector address.
- NMI_VEC, 16'hFFFA: NMI vector address.
- IRQ_VEC, 16'hFFFE: IRQ/BRK vector address.
- BRK_OPCODE, 8'h00: opcode forced onto data_out at an injected fetch.

Ports:
- ph1  in  1: single clock; all state updates on rising edge.
- reset  in  1: asynchronous, active-high reset.
- mem_data  in  8: byte from the memory data bus.
- last_cycle  in  1: from control; 1 = next cycle is an opcode fetch.
- vec_load  in  1: from control; 1 = vector high byte is loaded this cycle (service complete).
- p_i  in  1: processor I flag (1 = IRQ masked).
- nmi_b  in  1: NMI request, active-low, edge-triggered.
- irq_b  in  1: IRQ request, active-low, level-sensitive.
- data_out  out  8: byte presented to control data_in.
- int_active  out  1: 1 while an injected sequence is in progress.
- vector_addr  out  16: vector for the current/next break sequence.
- break_flag  out  1: B value to push (1 = software BRK, 0 = hardware interrupt).
- pc_inc_suppress  out  1: 1 during an injected fetch cycle (PC must not advance).

Behaviour:
- Registers: state{IDLE, INJECT, SERVICE}, src[1:0]{RST, NMI, IRQ, BRK}, reset_pend, nmi_pend, nmi_prev, break_flag.
- Reset (async): state=IDLE, reset_pend=1, nmi_pend=0, nmi_prev=1, src=RST, break_flag=0.
  - Outputs during reset: int_active=0, pc_inc_suppress=0, vector_addr=RESET_VEC, data_out=mem_data.
  - Reset asserted mid-sequence aborts the sequence; it restarts as a reset injection at the first boundary after release.
- NMI edge detection:
  - nmi_prev<=nmi_s every cycle.
  - An edge is nmi_prev=1 and nmi_s=0; it sets nmi_pend the same clock.
  - nmi_s is nmi_b, or its synchronized copy (see Optional Feature).
  - A second falling edge while nmi_pend=1 is absorbed, not counted.
- IRQ: irq_req = ~irq_s & ~p_i. It is evaluated combinationally only at a boundary and is never latched.
- IDLE, clock with last_cycle=1:
  - If reset_pend: src=RST. Else if nmi_pend: src=NMI. Else if irq_req: src=IRQ.
  - If any of these, go to INJECT; otherwise stay in IDLE.
- INJECT (exactly 1 cycle, the opcode fetch):
  - data_out=BRK_OPCODE, pc_inc_suppress=1, int_active=1, break_flag=0.
  - Clear reset_pend or nmi_pend according to src. Next state is SERVICE.
- Software BRK: in IDLE, if the previous cycle had last_cycle=1 and mem_data==BRK_OPCODE, then src=BRK, break_flag=1, and next state is SERVICE. pc_inc_suppress stays 0.
- SERVICE:
  - int_active=1; data_out=mem_data.
  - vector_addr selected by src: RST→RESET_VEC, NMI→NMI_VEC, IRQ/BRK→IRQ_VEC.
  - NMI hijack: if nmi_pend becomes 1 while src∈{IRQ, BRK} and vec_load=0, then src<=NMI, nmi_pend<=0, and break_flag is held.
  - On vec_load=1, go to IDLE the next clock. An NMI edge arriving in the same cycle as vec_load stays pending.
- IDLE outputs: data_out=mem_data, int_active=0, pc_inc_suppress=0. vector_addr reflects the last src.
- Simultaneous events at a boundary: priority is RST > NMI > IRQ. The losing source stays pending (NMI) or must still be asserted later (IRQ).
- last_cycle while not IDLE: ignored.

Optional Feature:
- Macro: INT_SYNC_EN.
- Defined: nmi_b and irq_b each pass through a 2-flop synchronizer reset to 1. This adds 2 cycles of latency from pin to nmi_pend or irq_req.
- Undefined: nmi_b and irq_b are used directly. nmi_pend rises on the first ph1 edge that samples nmi_b=0.

Test Plan:
- Release reset with last_cycle=1 on the first clock → next cycle data_out=8'h00, pc_inc_suppress=1, vector_addr=16'hFFFC, break_flag=0. vec_load=1 → int_active=0 one clock later.
- irq_b=0, p_i=0, boundary → injected 8'h00, vector 16'hFFFE, break_flag=0. Repeat with p_i=1 → data_out=mem_data and no injection.
- mem_data=8'h00 fetched normally → SERVICE, break_flag=1, vector 16'hFFFE, pc_inc_suppress=0 throughout.
- IRQ taken, then nmi_b falls 2 cycles before vec_load → vector_addr switches to 16'hFFFA and break_flag holds its value. Next boundary performs no further injection.
- irq_b=0 and NMI edge both present at the same boundary → NMI served first (16'hFFFA). IRQ served at the next boundary if still asserted.
- Assert reset during SERVICE of an NMI → outputs return to reset values. First boundary after release injects with vector 16'hFFFC.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: arbitrates reset/NMI/IRQ at instruction boundaries and injects BRK into the opcode stream.
// Optional INT_SYNC_EN: passes nmi_b and irq_b through 2-flop synchronizers before use.
module interrupt_sequencer #(
    parameter logic [15:0] RESET_VEC  = 16'hFFFC,
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
    parameter logic [7:0]  BRK_OPCODE = 8'h00
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [7:0]  mem_data,
    input  logic        last_cycle,
    input  logic        vec_load,
    input  logic        p_i,
    input  logic        nmi_b,
    input  logic        irq_b,
    output logic [7:0]  data_out,
    output logic        int_active,
    output logic [15:0] vector_addr,
    output logic        break_flag,
    output logic        pc_inc_suppress
);

    typedef enum logic [1:0] {IDLE, INJECT, SERVICE} state_t;
    typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

    state_t state;
    src_t   src;
    logic   reset_pend;
    logic   nmi_pend;
    logic   nmi_prev;
    logic   last_prev;
    logic   nmi_s;
    logic   irq_s;
    logic   irq_req;
    logic   nmi_edge;
    logic   nmi_clr;
    logic   hijack;

`ifdef INT_SYNC_EN
    logic [1:0] nmi_sync;
    logic [1:0] irq_sync;

    // Synchronizers idle high so reset never looks like a request
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            nmi_sync <= 2'b11;
            irq_sync <= 2'b11;
        end else begin
            nmi_sync <= {nmi_sync[0], nmi_b};
            irq_sync <= {irq_sync[0], irq_b};
        end
    end

    assign nmi_s = nmi_sync[1];
    assign irq_s = irq_sync[1];
`else
    assign nmi_s = nmi_b;
    assign irq_s = irq_b;
`endif

    assign irq_req  = ~irq_s & ~p_i;
    assign nmi_edge = nmi_prev & ~nmi_s;
    // An NMI arriving during an IRQ/BRK sequence takes over its vector unless the vector is already loading
    assign hijack   = (state == SERVICE) && nmi_pend && !vec_load &&
                      ((src == SRC_IRQ) || (src == SRC_BRK));
    assign nmi_clr  = ((state == INJECT) && (src == SRC_NMI)) || hijack;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            src        <= SRC_RST;
            reset_pend <= 1'b1;
            nmi_pend   <= 1'b0;
            nmi_prev   <= 1'b1;
            last_prev  <= 1'b0;
            break_flag <= 1'b0;
        end else begin
            nmi_prev  <= nmi_s;
            last_prev <= last_cycle;
            // A new edge wins over a same-cycle clear so it is never lost
            nmi_pend  <= nmi_edge | (nmi_pend & ~nmi_clr);
            case (state)
                IDLE: begin
                    if (last_prev && (mem_data == BRK_OPCODE)) begin
                        src        <= SRC_BRK;
                        break_flag <= 1'b1;
                        state      <= SERVICE;
                    end else if (last_cycle && (reset_pend || nmi_pend || irq_req)) begin
                        state      <= INJECT;
                        break_flag <= 1'b0;
                        if (reset_pend)    src <= SRC_RST;
                        else if (nmi_pend) src <= SRC_NMI;
                        else               src <= SRC_IRQ;
                    end
                end
                INJECT: begin
                    break_flag <= 1'b0;
                    if (src == SRC_RST) reset_pend <= 1'b0;
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (hijack) src <= SRC_NMI;
                    if (vec_load) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode directly from the registered state and source
    always_comb begin
        data_out        = mem_data;
        int_active      = 1'b0;
        pc_inc_suppress = 1'b0;
        vector_addr     = IRQ_VEC;
        if (state == INJECT) begin
            data_out        = BRK_OPCODE;
            pc_inc_suppress = 1'b1;
        end
        if (state != IDLE) int_active = 1'b1;
        case (src)
            SRC_RST: vector_addr = RESET_VEC;
            SRC_NMI: vector_addr = NMI_VEC;
            default: vector_addr = IRQ_VEC;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer (default build, no input synchronizers).
module tb_interrupt_sequencer;

    logic        ph1 = 1'b0;
    logic        reset;
    logic [7:0]  mem_data;
    logic        last_cycle;
    logic        vec_load;
    logic        p_i;
    logic        nmi_b;
    logic        irq_b;
    logic [7:0]  data_out;
    logic        int_active;
    logic [15:0] vector_addr;
    logic        break_flag;
    logic        pc_inc_suppress;

    int n_cmp = 0;
    int n_err = 0;

    interrupt_sequencer dut (
        .ph1             (ph1),
        .reset           (reset),
        .mem_data        (mem_data),
        .last_cycle      (last_cycle),
        .vec_load        (vec_load),
        .p_i             (p_i),
        .nmi_b           (nmi_b),
        .irq_b           (irq_b),
        .data_out        (data_out),
        .int_active      (int_active),
        .vector_addr     (vector_addr),
        .break_flag      (break_flag),
        .pc_inc_suppress (pc_inc_suppress)
    );

    always #5 ph1 = ~ph1;

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_data, input logic e_act,
                           input logic e_pc, input logic [15:0] e_vec, input logic e_brk);
        chk({tag, ".data_out"},   16'(data_out),        16'(e_data));
        chk({tag, ".int_active"}, 16'(int_active),      16'(e_act));
        chk({tag, ".pc_inc_sup"}, 16'(pc_inc_suppress), 16'(e_pc));
        chk({tag, ".vector"},     vector_addr,          e_vec);
        chk({tag, ".break"},      16'(break_flag),      16'(e_brk));
    endtask

    initial begin
        reset = 1'b1; mem_data = 8'hEA; last_cycle = 1'b0; vec_load = 1'b0;
        p_i = 1'b1; nmi_b = 1'b1; irq_b = 1'b1;
        tick(); tick();
        chk_all("reset", 8'hEA, 1'b0, 1'b0, 16'hFFFC, 1'b0);

        // Reset injection on first boundary after release
        reset = 1'b0; last_cycle = 1'b1;
        tick();
        chk_all("rst_inject", 8'h00, 1'b1, 1'b1, 16'hFFFC, 1'b0);
        last_cycle = 1'b0;
        tick();
        chk_all("rst_service", 8'hEA, 1'b1, 1'b0, 16'hFFFC, 1'b0);
        vec_load = 1'b1;
        tick();
        vec_load = 1'b0;
        chk_all("rst_done", 8'hEA, 1'b0, 1'b0, 16'hFFFC, 1'b0);

        // Unmasked IRQ at a boundary
        irq_b = 1'b0; p_i = 1'b0; last_cycle = 1'b1;
        tick();
        chk_all("irq_inject", 8'h00, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        irq_b = 1'b1; p_i = 1'b1; last_cycle = 1'b0;
        tick();
        chk_all("irq_service", 8'hEA, 1'b1, 1'b0, 16'hFFFE, 1'b0);
        vec_load = 1'b1;
        tick();
        vec_load = 1'b0;
        chk("irq_done.int_active", 16'(int_active), 16'h0);

        // Masked IRQ is not taken
        irq_b = 1'b0; p_i = 1'b1; last_cycle = 1'b1;
        tick();
        chk_all("irq_masked", 8'hEA, 1'b0, 1'b0, 16'hFFFE, 1'b0);
        irq_b = 1'b1; p_i = 1'b0; last_cycle = 1'b0;
        tick();
        chk("irq_masked2.int_active", 16'(int_active), 16'h0);

        // Software BRK fetched normally
        last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0; mem_data = 8'h00;
        #1;
        chk_all("brk_fetch", 8'h00, 1'b0, 1'b0, 16'hFFFE, 1'b0);
        tick();
        mem_data = 8'hEA;
        #1;
        chk_all("brk_service", 8'hEA, 1'b1, 1'b0, 16'hFFFE, 1'b1);
        vec_load = 1'b1;
        tick();
        vec_load = 1'b0;
        chk_all("brk_done", 8'hEA, 1'b0, 1'b0, 16'hFFFE, 1'b1);

        // NMI hijacks an IRQ sequence two cycles before vec_load
        irq_b = 1'b0; last_cycle = 1'b1;
        tick();
        chk_all("hij_inject", 8'h00, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        irq_b = 1'b1; last_cycle = 1'b0;
        tick();
        nmi_b = 1'b0;
        tick();
        chk("hij_pend.vector", vector_addr, 16'hFFFE);
        tick();
        chk_all("hij_switch", 8'hEA, 1'b1, 1'b0, 16'hFFFA, 1'b0);
        vec_load = 1'b1;
        tick();
        vec_load = 1'b0; nmi_b = 1'b1;
        chk_all("hij_done", 8'hEA, 1'b0, 1'b0, 16'hFFFA, 1'b0);
        last_cycle = 1'b1;
        tick();
        chk_all("hij_no_reinject", 8'hEA, 1'b0, 1'b0, 16'hFFFA, 1'b0);
        last_cycle = 1'b0;
        tick();

        // NMI and IRQ together: NMI first, IRQ at the following boundary
        nmi_b = 1'b0; irq_b = 1'b0;
        tick();
        last_cycle = 1'b1;
        tick();
        chk_all("both_nmi", 8'h00, 1'b1, 1'b1, 16'hFFFA, 1'b0);
        last_cycle = 1'b0;
        tick();
        vec_load = 1'b1;
        tick();
        vec_load = 1'b0;
        chk("both_nmi_done.int_active", 16'(int_active), 16'h0);
        last_cycle = 1'b1;
        tick();
        chk_all("both_irq", 8'h00, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        irq_b = 1'b1; nmi_b = 1'b1; last_cycle = 1'b0;
        tick();
        vec_load = 1'b1;
        tick();
        vec_load = 1'b0;

        // Reset during NMI service
        nmi_b = 1'b0;
        tick();
        last_cycle = 1'b1;
        tick();
        last_cycle = 1'b0;
        tick();
        chk_all("nmi_service", 8'hEA, 1'b1, 1'b0, 16'hFFFA, 1'b0);
        reset = 1'b1;
        #1;
        chk_all("mid_reset", 8'hEA, 1'b0, 1'b0, 16'hFFFC, 1'b0);
        nmi_b = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_idle.int_active", 16'(int_active), 16'h0);
        last_cycle = 1'b1;
        tick();
        chk_all("post_reset_inject", 8'h00, 1'b1, 1'b1, 16'hFFFC, 1'b0);
        last_cycle = 1'b0;
        tick();
        vec_load = 1'b1;
        tick();
        vec_load = 1'b0;
        chk("post_reset_done.int_active", 16'(int_active), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
